// File: rtl/ureg_n.sv
// WIDTH-bit universal register: hold/load/shift/count/rotate chosen per cycle by mode.
// One cycle from edge to q; no backpressure, a new mode is accepted on every edge.
module ureg_n #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             tc,
   output logic             ovf
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_UP   = 3'b100,
      MODE_DN   = 3'b101,
      MODE_ROL  = 3'b110,
      MODE_ROR  = 3'b111
   } mode_t;

   mode_t            mode_e;
   logic [WIDTH-1:0] q_nxt;
   logic             at_max;
   logic             at_min;
   logic             hold_lim;

   assign mode_e = mode_t'(mode);
   assign at_max = &q;
   assign at_min = ~|q;

   // tc doubles as the cascade carry, so it must not wait for the edge
   assign tc       = ((mode_e == MODE_UP) && at_max) || ((mode_e == MODE_DN) && at_min);
   assign hold_lim = tc && SATURATE;

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

   always_comb begin
      q_nxt = q;
      case (mode_e)
         MODE_HOLD: q_nxt = q;
         MODE_LOAD: q_nxt = d;
         MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
         MODE_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
         MODE_UP:   q_nxt = hold_lim ? q : q + WIDTH'(1);
         MODE_DN:   q_nxt = hold_lim ? q : q - WIDTH'(1);
         MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
      endcase
   end

   // ovf fires on every limit edge, including repeated edges while saturated
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= RST_VAL;
         ovf <= 1'b0;
      end else begin
         q   <= q_nxt;
         ovf <= tc;
      end
   end

endmodule

// File: doc/ureg_n.md
Name: ureg_n

Overview:
- Parametrised WIDTH-bit universal register. Successor to the single-bit dff/dffr/dffrs flops.
- Per-cycle modes: hold, parallel load, shift left/right with serial in/out, count up/down, rotate left/right.
- Selectable wrap or saturate counting, terminal-count flag and registered overflow pulse.
- Used as the standard building block for counters, delay lines and FSM state/timer registers.

Parameters:
- WIDTH, 8, register width in bits; legal range ≥ 2.
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).
- SATURATE, 0, 0 = counter wraps modulo 2^WIDTH; 1 = counter holds at the limit.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB during shift right.
- sin_r  input  1  serial input entering at the LSB during shift left.
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1]; combinational from q.
- sout_r  output  1  equals q[0]; combinational from q.
- tc  output  1  terminal count; combinational.
- ovf  output  1  registered one-cycle overflow/underflow pulse.

Behaviour:
- Reset
  - rst=1 at a rising edge: q<=RST_VAL, ovf<=0.
  - Reset has priority over every mode. Reset mid-count or mid-shift discards the operation.
  - No asynchronous paths exist.
- Mode decode, applied at each rising edge with rst=0:
  - 000 hold: q<=q.
  - 001 load: q<=d.
  - 010 shift left: q<={q[W-2:0],sin_r}.
  - 011 shift right: q<={sin_l,q[W-1:1]}.
  - 100 count up.
  - 101 count down.
  - 110 rotate left: q<={q[W-2:0],q[W-1]}.
  - 111 rotate right: q<={q[0],q[W-1:1]}.
- Counting
  - Count up: q<=q+1 (unsigned, WIDTH bits).
  - At q=all-ones: SATURATE=0 gives q<=0; SATURATE=1 gives q unchanged.
  - Count down: q<=q-1.
  - At q=0: SATURATE=0 gives q<=all-ones; SATURATE=1 gives q unchanged.
- tc
  - tc=1 when (mode=100 and q=all-ones) or (mode=101 and q=0); otherwise 0.
  - Purely combinational; usable as a carry for cascading.
- ovf
  - ovf<=1 on an edge where the counter was at its limit with tc=1 in a count mode; ovf<=0 on every other edge.
  - Pulse lasts exactly one cycle per limit event and is asserted in the cycle after the wrapping edge.
  - Holding count-up with SATURATE=1 at max re-asserts ovf every cycle.
- Latency
  - All modes: 1 cycle from edge to q.
  - sout_l/sout_r/tc follow q with no added cycle.
- Mode changes take effect on the next edge without restriction; no illegal mode exists.
- d, sin_l and sin_r are ignored in modes that do not use them.

Test Plan:
- WIDTH=8, RST_VAL=8'hA5: hold rst=1 for 1 edge, then mode=000 for 3 edges -> q=8'hA5 throughout, ovf=0.
- Load then shift:
  - mode=001, d=8'h81 -> q=8'h81.
  - mode=010, sin_r=0 -> q=8'h02, sout_l was 1 before the edge.
  - mode=011, sin_l=1 -> q=8'h81.
- Rotate: load 8'h81, then mode=110 -> q=8'h03; then mode=111 twice -> q=8'hC0.
- SATURATE=0, count up:
  - Load 8'hFE, then 3 count-up edges -> q=FF, 00, 01.
  - tc=1 only while q=FF.
  - ovf=1 only in the cycle where q=00.
- SATURATE=1:
  - Load 8'h01, then 3 count-down edges -> q=00, 00, 00; ovf=1 in the 2nd and 3rd result cycles.
  - Then 2 count-up edges -> q=01, 02 with ovf=0.
- Reset mid-count: count up from 8'h10 for 2 edges, assert rst with mode=100 -> q=RST_VAL next cycle, ovf=0; counting resumes from RST_VAL after rst=0.
